// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: owner codes, arbiter states and default depth shared by the arbiter files.
package mem_req_arbiter_pkg;
  localparam logic ARB_OWN_INST = 1'b0;
  localparam logic ARB_OWN_DATA = 1'b1;
  localparam int ARB_OUTSTANDING = 4;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// arb_owner_fifo: 1-bit-wide in-order owner FIFO; a push is dropped when full even if a pop coincides.
module arb_owner_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = ARB_OUTSTANDING
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push_ok, pop_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one sram-like port between inst and data requesters, routing responses in order.
// Define MEM_ARB_RR_EN for round-robin between simultaneous requests; default is fixed data priority.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = ARB_OUTSTANDING
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);
  arb_state_e state, state_n;
  logic idle_sel, sel_data, win_req, hs, pop, fifo_full, fifo_empty, head;
`ifdef MEM_ARB_RR_EN
  logic last_own;
  always_ff @(posedge clk) begin
    if (reset) last_own <= ARB_OWN_INST;
    else if (hs) last_own <= sel_data;
  end
  assign idle_sel = (inst_req && data_req) ? (last_own == ARB_OWN_INST) : data_req;
`else
  assign idle_sel = data_req;
`endif
  // A locked grant keeps the slave request stable until addr_ok, whatever the other side does.
  assign sel_data = (state == ARB_DATA) ? 1'b1 : (state == ARB_INST) ? 1'b0 : idle_sel;
  assign win_req = sel_data ? data_req : inst_req;
  assign sram_req = win_req && !fifo_full && !reset;
  assign sram_wr = sel_data ? data_wr : inst_wr;
  assign sram_size = sel_data ? data_size : inst_size;
  assign sram_wstrb = sel_data ? data_wstrb : inst_wstrb;
  assign sram_addr = sel_data ? data_addr : inst_addr;
  assign sram_wdata = sel_data ? data_wdata : inst_wdata;
  assign hs = sram_req && sram_addr_ok;
  assign inst_addr_ok = hs && !sel_data;
  assign data_addr_ok = hs && sel_data;
  assign pop = sram_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = pop && head == ARB_OWN_INST;
  assign data_data_ok = pop && head == ARB_OWN_DATA;
  assign inst_rdata = sram_rdata;
  assign data_rdata = sram_rdata;
  always_comb begin
    state_n = hs ? ARB_IDLE
            : (win_req && (sram_req || state != ARB_IDLE)) ? (sel_data ? ARB_DATA : ARB_INST)
            : ARB_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else state <= state_n;
  end
  arb_owner_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (hs),
    .din  (sel_data),
    .pop  (pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (head)
  );
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized requesters and slave against a queue-based model, with an in-order response scoreboard.
module tb_mem_req_arbiter;
  localparam int OUT = 4;
  logic clk = 1'b0;
  logic reset;
  logic inst_req, inst_wr, data_req, data_wr;
  logic [1:0] inst_size, data_size;
  logic [3:0] inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic sram_req, sram_wr;
  logic [1:0] sram_size;
  logic [3:0] sram_wstrb;
  logic [31:0] sram_addr, sram_wdata;
  logic sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;
  int checks = 0;
  int errors = 0;
  logic own_q [$];
  logic [32:0] exp_q [$];
  int holder = -1;
  logic last = 1'b0;
  bit ipend = 0, dpend = 0;

  always #5 clk = ~clk;

  mem_req_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_i, input int p_req, input int p_aok, input int p_dok);
    int win;
    bit full, exp_req, dok;
    logic [38:0] exp_fields;
    @(negedge clk);
    reset = rst_i;
    if (!ipend && $urandom_range(99) < p_req) begin
      ipend = 1;
      inst_wr = 1'($urandom); inst_size = 2'($urandom_range(2)); inst_wstrb = 4'($urandom);
      inst_addr = $urandom; inst_wdata = $urandom;
    end
    if (!dpend && $urandom_range(99) < p_req) begin
      dpend = 1;
      data_wr = 1'($urandom); data_size = 2'($urandom_range(2)); data_wstrb = 4'($urandom);
      data_addr = $urandom; data_wdata = $urandom;
    end
    inst_req = ipend;
    data_req = dpend;
    sram_addr_ok = $urandom_range(99) < p_aok;
    dok = $urandom_range(99) < p_dok;
    sram_data_ok = dok;
    sram_rdata = $urandom;
    #1;
    full = own_q.size() >= OUT;
    if (holder >= 0) win = holder;
    else if (ipend && dpend) begin
`ifdef MEM_ARB_RR_EN
      win = (last == 1'b0) ? 1 : 0;
`else
      win = 1;
`endif
    end else win = dpend ? 1 : ipend ? 0 : -1;
    exp_req = !rst_i && win >= 0 && !full;
    chk("sram_req", 64'(sram_req), 64'(exp_req));
    if (exp_req) begin
      exp_fields = (win == 1) ? {data_wr, data_size, data_wstrb, data_wdata}
                              : {inst_wr, inst_size, inst_wstrb, inst_wdata};
      chk("sram_addr", 64'(sram_addr), 64'((win == 1) ? data_addr : inst_addr));
      chk("sram_fields", 64'({sram_wr, sram_size, sram_wstrb, sram_wdata}), 64'(exp_fields));
    end
    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(exp_req && sram_addr_ok && win == 0));
    chk("data_addr_ok", 64'(data_addr_ok), 64'(exp_req && sram_addr_ok && win == 1));
    if (!rst_i && dok && own_q.size() > 0) exp_q.push_back({own_q.pop_front(), sram_rdata});
    if (exp_req && sram_addr_ok) begin
      own_q.push_back(win == 1);
      last = (win == 1);
      holder = -1;
      if (win == 1) dpend = 0; else ipend = 0;
    end else if (exp_req) holder = win;
    if (rst_i) begin
      own_q.delete();
      holder = -1;
      last = 1'b0;
      ipend = 0;
      dpend = 0;
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    if (inst_data_ok && data_data_ok) chk("dual_data_ok", 64'(2'b11), 64'(2'b01));
    else if (inst_data_ok || data_data_ok) begin
      if (exp_q.size() == 0) chk("spurious_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("resp_owner", 64'(data_data_ok), 64'(e[32]));
        chk("resp_rdata", 64'(data_data_ok ? data_rdata : inst_rdata), 64'(e[31:0]));
      end
    end else if (exp_q.size() != 0) begin
      chk("missing_data_ok", 64'(0), 64'(exp_q.size()));
      exp_q.delete();
    end
  end

  initial begin
    reset = 1'b1;
    {inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata} = '0;
    {data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata} = '0;
    {sram_addr_ok, sram_data_ok, sram_rdata} = '0;
    repeat (4) step(1, 80, 80, 80);
    for (int i = 0; i < 600; i++) step($urandom_range(99) == 0, 50, 60, 40);
    for (int i = 0; i < 300; i++) step(0, 70, 90, 10);
    for (int i = 0; i < 200; i++) step(0, 100, 100, 50);
    for (int i = 0; i < 200; i++) step(0, 10, 70, 90);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 20; i++) step(0, 90, 90, 5);
      step(1, 90, 90, 90);
      for (int i = 0; i < 10; i++) step(0, 0, 90, 100);
    end
    for (int i = 0; i < 200; i++) step(0, 50, 50, 50);
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares one sram-like memory port between the instruction-fetch requester and the data (load/store) requester of the pipelined CPU. Grants one requester per address handshake, holds the grant until the slave returns addr_ok, and records each accepted request's owner in an in-order FIFO so every slave data_ok/rdata is routed back to the requester that issued it. Sits between the IF/EX/MEM stages and the AXI bridge and adds zero cycles of latency.

## Interface
- OUTSTANDING, 4: maximum accepted-but-unanswered requests; power of two, 2..16.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst_req / data_req  in  1  request valid (per requester).
- inst_wr / data_wr  in  1  write when 1.
- inst_size / data_size  in  2  0=byte, 1=half, 2=word.
- inst_wstrb / data_wstrb  in  4  byte enables.
- inst_addr / data_addr  in  32  address.
- inst_wdata / data_wdata  in  32  write data.
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle.
- inst_data_ok / data_data_ok  out  1  response for this requester this cycle.
- inst_rdata / data_rdata  out  32  response data (valid with the matching data_ok).
- sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata  out  1/1/2/4/32/32  muxed request to slave.
- sram_addr_ok  in  1  slave accepted request.
- sram_data_ok  in  1  slave response valid.
- sram_rdata  in  32  slave response data.

## Operation
- State machine: ARB_IDLE, ARB_INST (grant locked to inst), ARB_DATA (grant locked to data).
- ARB_IDLE: winner chosen combinationally from inst_req/data_req; default policy fixed data priority. Winner's fields drive sram_*; sram_req = winner's req AND !fifo_full.
- Handshake completes when sram_req && sram_addr_ok: winner's *_addr_ok = 1, owner pushed to FIFO, next state ARB_IDLE.
- sram_req asserted without sram_addr_ok: move to ARB_INST/ARB_DATA; grant held, sram_* follows the locked requester until addr_ok, then ARB_IDLE. The other requester waits even if higher priority (sram-like requires request stability).
- Loser's addr_ok = 0. Requester fields never mixed.
- Owner FIFO: OUTSTANDING entries, 1 bit each (ARB_OWN_INST/ARB_OWN_DATA), count width clog2(OUTSTANDING)+1, pointers wrap modulo OUTSTANDING.
- fifo_full: no new sram_req (held state keeps request pending, sram_req low) until a pop frees an entry; push in the same cycle as a pop on full is not permitted (full gates push regardless of pop).
- sram_data_ok with FIFO non-empty: pop head; head owner's *_data_ok = 1; sram_rdata copied to both *_rdata (only the flagged one is meaningful).
- sram_data_ok with FIFO empty: ignored, no output pulse, no state change.
- Simultaneous push and pop (not full): both occur, count unchanged.
- Writes also occupy a FIFO entry; their data_ok is routed identically.

## Timing
- Request path combinational: requester → sram_* same cycle; sram_addr_ok → *_addr_ok same cycle.
- Response path combinational from FIFO head: sram_data_ok → *_data_ok same cycle. Zero added latency.
- Back-to-back: one request accepted per cycle when slave gives addr_ok every cycle and FIFO not full.
- Reset: state ARB_IDLE, FIFO empty (count 0, pointers 0), last-grant register = inst. While reset is high sram_req, *_addr_ok, *_data_ok are forced 0; *_rdata = sram_rdata.
- Reset mid-transaction drops all outstanding owners; responses arriving afterwards hit the empty-FIFO rule and are discarded.

## Configuration
- MEM_ARB_RR_EN defined: in ARB_IDLE with both requesting, grant goes to the requester not granted last; last-grant register updated on every completed handshake.
- MEM_ARB_RR_EN undefined: fixed data priority; last-grant register absent.
- Single-requester and locked-state behaviour identical in both builds.

## Structure
- Shared header/package: ARB_OWN_INST (0), ARB_OWN_DATA (1), state encodings ARB_IDLE/ARB_INST/ARB_DATA, default OUTSTANDING.
- One sub-module: arb_owner_fifo (1-bit-wide, OUTSTANDING-deep synchronous FIFO with push, pop, full, empty, head).

## Test plan
- Both request in one cycle, slave addr_ok=1 → data_addr_ok=1, sram_addr=data_addr; inst granted next cycle (priority build).
- inst granted, slave addr_ok low 3 cycles, data_req rises cycle 1 → sram_addr stays inst_addr for 4 cycles, then inst_addr_ok=1, data served next.
- Issue inst, data, inst; slave returns rdata 0x11,0x22,0x33 in order → inst_data_ok(0x11), data_data_ok(0x22), inst_data_ok(0x33).
- OUTSTANDING=4, five requests with no data_ok → fifth sees sram_req=0; one data_ok → fifth accepted next cycle.
- sram_data_ok=1 with FIFO empty, and after reset mid-flight → no *_data_ok pulses.
- MEM_ARB_RR_EN, both requesting continuously with addr_ok=1 → grants alternate data, inst, data, inst.
